// File: rtl/pipelined_control.sv
// pipelined_control: opcode decode into WB/MEM/EX/jump/branch bundles, owns the ID/EX control register,
// inserts bubbles for load-use hazards and for FLUSH_CYCLES cycles after a flush. Latency: 1 cycle.
// Backpressure: stall_in holds the register; hazard_stall_out freezes PC/IF-ID. Option: ILLEGAL_OP_TRAP_EN.
module pipelined_control #(
    parameter int OPCODE_W     = 6,
    parameter int REG_ADDR_W   = 5,
    parameter int ALU_OP_W     = 3,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [OPCODE_W-1:0]   op_code_in,
    input  logic [REG_ADDR_W-1:0] rs_in,
    input  logic [REG_ADDR_W-1:0] rt_in,
    input  logic                  stall_in,
    input  logic                  flush_in,
    output logic [1:0]            WB_out,
    output logic [1:0]            MEM_out,
    output logic [ALU_OP_W+1:0]   EX_out,
    output logic                  jump_out,
    output logic                  branch_out,
    output logic [REG_ADDR_W-1:0] ex_rt_out,
    output logic                  hazard_stall_out
`ifdef ILLEGAL_OP_TRAP_EN
    ,
    output logic                  illegal_op_out
`endif
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'b000101);
    localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] OP_SLTI  = OPCODE_W'(6'b001010);
    localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(6'b001100);
    localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(6'b001101);
    localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);

    typedef struct packed {
        logic                reg_write;
        logic                mem_to_reg;
        logic                mem_read;
        logic                mem_write;
        logic                reg_dest;
        logic [ALU_OP_W-1:0] alu_op;
        logic                alu_src;
        logic                jump;
        logic                branch;
    } ctrl_t;

    ctrl_t                 dec;
    logic                  dec_uses_rt;
    logic                  dec_illegal;
    logic                  hazard;

    ctrl_t                 ctrl_q, ctrl_d;
    logic [REG_ADDR_W-1:0] ex_rt_q, ex_rt_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  illegal_q, illegal_d;

    always_comb begin
        dec         = '0;
        dec_uses_rt = 1'b0;
        dec_illegal = 1'b0;
        case (op_code_in)
            OP_RTYPE: begin
                dec.reg_dest  = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = ALU_OP_W'(3'd2);
                dec_uses_rt   = 1'b1;
            end
            OP_J: dec.jump = 1'b1;
            OP_BEQ, OP_BNE: begin
                dec.alu_op  = ALU_OP_W'(3'd1);
                dec.branch  = 1'b1;
                dec_uses_rt = 1'b1;
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                case (op_code_in)
                    OP_SLTI: dec.alu_op = ALU_OP_W'(3'd5);
                    OP_ANDI: dec.alu_op = ALU_OP_W'(3'd3);
                    OP_ORI:  dec.alu_op = ALU_OP_W'(3'd4);
                    default: dec.alu_op = '0;
                endcase
            end
            OP_LW: begin
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
            end
            OP_SW: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec_uses_rt   = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Register 0 is hardwired, so a load targeting it can never create a dependency.
    assign hazard = ctrl_q.mem_read && (ex_rt_q != '0) &&
                    ((ex_rt_q == rs_in) || ((ex_rt_q == rt_in) && dec_uses_rt));

    assign hazard_stall_out = hazard && !rst && !flush_in && (cnt_q == '0);

    always_comb begin
        ctrl_d    = ctrl_q;
        ex_rt_d   = ex_rt_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        if (flush_in) begin
            ctrl_d  = '0;
            ex_rt_d = '0;
            cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
        end else if (cnt_q != '0) begin
            ctrl_d  = '0;
            ex_rt_d = '0;
            cnt_d   = cnt_q - CNT_W'(1);
        end else if (stall_in) begin
            ctrl_d  = ctrl_q;
        end else if (hazard) begin
            ctrl_d  = '0;
            ex_rt_d = '0;
        end else begin
            ctrl_d    = dec;
            ex_rt_d   = rt_in;
            illegal_d = illegal_q | dec_illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q    <= '0;
            ex_rt_q   <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            ex_rt_q   <= ex_rt_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    assign WB_out     = {ctrl_q.reg_write, ctrl_q.mem_to_reg};
    assign MEM_out    = {ctrl_q.mem_read, ctrl_q.mem_write};
    assign EX_out     = {ctrl_q.reg_dest, ctrl_q.alu_op, ctrl_q.alu_src};
    assign jump_out   = ctrl_q.jump;
    assign branch_out = ctrl_q.branch;
    assign ex_rt_out  = ex_rt_q;

`ifdef ILLEGAL_OP_TRAP_EN
    assign illegal_op_out = illegal_q;
`else
    logic unused_illegal;
    assign unused_illegal = illegal_q;
`endif

endmodule

// File: tb/tb_pipelined_control.sv
// Directed bench for pipelined_control built with FLUSH_CYCLES=3; expected bundles are hand-computed.
module tb_pipelined_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op_code_in;
    logic [4:0] rs_in, rt_in;
    logic       stall_in, flush_in;
    logic [1:0] WB_out, MEM_out;
    logic [4:0] EX_out;
    logic       jump_out, branch_out;
    logic [4:0] ex_rt_out;
    logic       hazard_stall_out;
`ifdef ILLEGAL_OP_TRAP_EN
    logic       illegal_op_out;
`endif

    int checks   = 0;
    int failures = 0;

    pipelined_control #(
        .OPCODE_W(6), .REG_ADDR_W(5), .ALU_OP_W(3), .FLUSH_CYCLES(3)
    ) dut (
        .clk(clk), .rst(rst), .op_code_in(op_code_in), .rs_in(rs_in), .rt_in(rt_in),
        .stall_in(stall_in), .flush_in(flush_in), .WB_out(WB_out), .MEM_out(MEM_out),
        .EX_out(EX_out), .jump_out(jump_out), .branch_out(branch_out),
        .ex_rt_out(ex_rt_out), .hazard_stall_out(hazard_stall_out)
`ifdef ILLEGAL_OP_TRAP_EN
        , .illegal_op_out(illegal_op_out)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [5:0] RT = 6'b000000, J = 6'b000010, BEQ = 6'b000100, BNE = 6'b000101,
                           ADDI = 6'b001000, SLTI = 6'b001010, ANDI = 6'b001100,
                           ORI = 6'b001101, LW = 6'b100011, SW = 6'b101011, ILL = 6'b111111;

    // {WB, MEM, EX, jump, branch} for each opcode
    localparam logic [10:0] B_R    = {2'b10, 2'b00, 5'b10100, 1'b0, 1'b0};
    localparam logic [10:0] B_J    = {2'b00, 2'b00, 5'b00000, 1'b1, 1'b0};
    localparam logic [10:0] B_BR   = {2'b00, 2'b00, 5'b00010, 1'b0, 1'b1};
    localparam logic [10:0] B_ADDI = {2'b10, 2'b00, 5'b00001, 1'b0, 1'b0};
    localparam logic [10:0] B_SLTI = {2'b10, 2'b00, 5'b01011, 1'b0, 1'b0};
    localparam logic [10:0] B_ANDI = {2'b10, 2'b00, 5'b00111, 1'b0, 1'b0};
    localparam logic [10:0] B_ORI  = {2'b10, 2'b00, 5'b01001, 1'b0, 1'b0};
    localparam logic [10:0] B_LW   = {2'b11, 2'b10, 5'b00001, 1'b0, 1'b0};
    localparam logic [10:0] B_SW   = {2'b00, 2'b01, 5'b00001, 1'b0, 1'b0};
    localparam logic [10:0] B_NOP  = 11'd0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag, input logic [10:0] bundle, input logic [4:0] rt);
        check(tag, {16'd0, WB_out, MEM_out, EX_out, jump_out, branch_out, ex_rt_out},
              {16'd0, bundle, rt});
    endtask

    task automatic set_in(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
        op_code_in = op;
        rs_in      = rs;
        rt_in      = rt;
        #1;
    endtask

    logic [5:0]  sw_op [11];
    logic [10:0] sw_exp[11];

    initial begin
        rst = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
        set_in(LW, 5'd0, 5'd5);
        tick(); tick();
        check_regs("reset_regs", B_NOP, 5'd0);
        check("reset_hazard", {31'd0, hazard_stall_out}, 32'd0);
`ifdef ILLEGAL_OP_TRAP_EN
        check("reset_illegal", {31'd0, illegal_op_out}, 32'd0);
`endif
        rst = 1'b0;
        tick();
        check_regs("first_lw", B_LW, 5'd5);

        // load-use on rs
        set_in(RT, 5'd5, 5'd6);
        check("lu_hazard", {31'd0, hazard_stall_out}, 32'd1);
        tick();
        check_regs("lu_bubble", B_NOP, 5'd0);
        check("lu_hazard_gone", {31'd0, hazard_stall_out}, 32'd0);
        tick();
        check_regs("lu_add", B_R, 5'd6);

        // load to register 0 never stalls
        set_in(LW, 5'd0, 5'd0);
        tick();
        check_regs("lw_r0", B_LW, 5'd0);
        set_in(RT, 5'd0, 5'd0);
        check("r0_no_hazard", {31'd0, hazard_stall_out}, 32'd0);
        tick();
        check_regs("add_after_r0", B_R, 5'd0);

        // back-to-back lw and rt usage
        set_in(LW, 5'd3, 5'd7);
        tick();
        set_in(LW, 5'd3, 5'd7);
        check("lw_lw_rt_only", {31'd0, hazard_stall_out}, 32'd0);
        set_in(LW, 5'd7, 5'd2);
        check("lw_lw_rs", {31'd0, hazard_stall_out}, 32'd1);
        set_in(SW, 5'd1, 5'd7);
        check("lw_sw_rt", {31'd0, hazard_stall_out}, 32'd1);
        set_in(ADDI, 5'd1, 5'd7);
        check("lw_addi_rt", {31'd0, hazard_stall_out}, 32'd0);
        tick();
        check_regs("addi_load", B_ADDI, 5'd7);

        // stall holds state and does not mask the hazard
        set_in(LW, 5'd0, 5'd3);
        tick();
        stall_in = 1'b1;
        set_in(RT, 5'd3, 5'd9);
        check("stall_hazard_vis", {31'd0, hazard_stall_out}, 32'd1);
        tick();
        check_regs("stall_hold_lw", B_LW, 5'd3);
        stall_in = 1'b0;
        tick();
        check_regs("post_stall_bubble", B_NOP, 5'd0);
        tick();
        check_regs("post_stall_add", B_R, 5'd9);
        set_in(BEQ, 5'd1, 5'd2);
        tick();
        check_regs("beq_load", B_BR, 5'd2);
        stall_in = 1'b1;
        set_in(J, 5'd0, 5'd0);
        tick();
        check_regs("beq_hold1", B_BR, 5'd2);
        tick();
        check_regs("beq_hold2", B_BR, 5'd2);
        stall_in = 1'b0;
        tick();
        check_regs("j_after_stall", B_J, 5'd0);

        // flush: three bubbles, flushed op never loaded
        set_in(LW, 5'd0, 5'd4);
        tick();
        flush_in = 1'b1;
        set_in(ORI, 5'd4, 5'd0);
        check("flush_masks_hazard", {31'd0, hazard_stall_out}, 32'd0);
        tick();
        check_regs("flush_b1", B_NOP, 5'd0);
        flush_in = 1'b0;
        set_in(ANDI, 5'd0, 5'd0);
        tick();
        check_regs("flush_b2", B_NOP, 5'd0);
        tick();
        check_regs("flush_b3", B_NOP, 5'd0);
        tick();
        check_regs("flush_load", B_ANDI, 5'd0);

        // flush while counter nonzero reloads it
        flush_in = 1'b1;
        set_in(ADDI, 5'd0, 5'd0);
        tick();
        tick();
        flush_in = 1'b0;
        #1;
        tick();
        check_regs("reload_b1", B_NOP, 5'd0);
        tick();
        check_regs("reload_b2", B_NOP, 5'd0);
        tick();
        check_regs("reload_load", B_ADDI, 5'd0);

        // reset mid-flush clears the counter
        flush_in = 1'b1;
        set_in(SW, 5'd0, 5'd0);
        tick();
        flush_in = 1'b0;
        rst = 1'b1;
        tick();
        check_regs("rst_mid_flush", B_NOP, 5'd0);
        rst = 1'b0;
        set_in(ADDI, 5'd0, 5'd0);
        tick();
        check_regs("post_rst_load", B_ADDI, 5'd0);

        // decode sweep
        sw_op  = '{RT, J, BEQ, BNE, ADDI, SLTI, ANDI, ORI, LW, SW, ILL};
        sw_exp = '{B_R, B_J, B_BR, B_BR, B_ADDI, B_SLTI, B_ANDI, B_ORI, B_LW, B_SW, B_NOP};
        for (int i = 0; i < 11; i++) begin
            set_in(sw_op[i], 5'd0, 5'd0);
            tick();
            check_regs($sformatf("sweep_op%0h", sw_op[i]), sw_exp[i], 5'd0);
        end
`ifdef ILLEGAL_OP_TRAP_EN
        check("illegal_set", {31'd0, illegal_op_out}, 32'd1);
        set_in(ADDI, 5'd0, 5'd0);
        tick();
        check("illegal_sticky", {31'd0, illegal_op_out}, 32'd1);
        rst = 1'b1;
        tick();
        check("illegal_rst", {31'd0, illegal_op_out}, 32'd0);
        rst = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
